alu_iter: RTL and testbench
===========================

# alu_iter

Parametrised, registered ALU for the RISC-V core, extending the base single-cycle op set with XOR, unsigned compare, shifts, and iterative multiply/divide. Operands and opcode are captured on a Start handshake. Single-cycle ops complete on the capture edge; MUL/DIVU/REMU run a WIDTH-step shift-add or restoring-division sequence. Sits between the register file/immediate mux and the writeback mux, and stalls the pipeline via Busy.

## Interface
- WIDTH, 32, datapath width; power of two, ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (localparam, derived)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- Start  in  1  request; sampled only in IDLE
- SrcA  in  WIDTH  first operand
- SrcB  in  WIDTH  second operand; shift amount = SrcB[SHW-1:0]
- ALUControl  in  4  operation select
- Busy  out  1  high while an iterative op is running
- Done  out  1  one-cycle pulse: ALUResult valid and updated
- Zero  out  1  (ALUResult == 0), combinational from the result register
- ALUResult  out  WIDTH  registered result; holds until the next completion

## Operation
- Opcodes:
  - 0000 add
  - 0001 sub
  - 0010 and
  - 0011 or
  - 0100 xor
  - 0101 slt (signed)
  - 0110 sltu
  - 0111 sll
  - 1000 srl
  - 1001 sra
  - 1100 mul (low WIDTH bits)
  - 1101 divu
  - 1110 remu
  - All other codes: result 0, single-cycle.
- Add/sub: one adder, B inverted and carry-in 1 for sub/slt/sltu. Wrap modulo 2^WIDTH, no overflow flag.
- slt: if the operand signs differ, result = SrcA MSB; otherwise result = MSB of A−B. sltu: result = NOT carry-out of A−B. Both zero-extended to WIDTH.
- States: IDLE, RUN.
- IDLE + Start + single-cycle op:
  - ALUResult ← result, Done ← 1.
  - Stay IDLE.
- IDLE + Start + mul/divu/remu:
  - Latch operands and op; count ← 0; Busy ← 1.
  - Go to RUN.
- RUN: one iteration per edge, count++.
  - On the edge with count == WIDTH−1: write ALUResult, pulse Done, clear Busy, go to IDLE.
- mul: shift-add, multiplier LSB-first; keep the low WIDTH bits only.
- divu/remu: restoring division, one quotient bit per step, MSB-first.
- Divide by zero: no special path; restoring division naturally yields quotient all-ones and remainder = SrcA. Still takes WIDTH cycles.
- Start while Busy: ignored, not queued. SrcA, SrcB and ALUControl changes during RUN have no effect.
- Start in the Done cycle: accepted (state is IDLE).
- Reset has priority over everything, including mid-RUN: abort the op, state IDLE, Busy 0, Done 0, ALUResult 0, Zero 1, count 0.

## Timing
- Start sampled at edge k:
  - Single-cycle op: Done=1 and new ALUResult in the cycle after edge k (latency 1).
  - Iterative op: Busy=1 in the cycles after edges k .. k+WIDTH−1; Done=1 and new ALUResult in the cycle after edge k+WIDTH (latency WIDTH+1).
- Done lasts exactly one cycle. Busy and Done are never high together.
- ALUResult and Zero change only on a Done edge or on reset.
- Throughput:
  - One single-cycle op per cycle.
  - Back-to-back iterative ops with no idle gap: the next Start can be given in the Done cycle.

## Structure
- Package alu_pkg holds:
  - ALUControl opcode localparams (4-bit)
  - the IDLE/RUN state encoding
  - a helper function is_iter(op)
- Sub-module alu_muldiv holds the iterative datapath: accumulator/remainder, multiplier/quotient shift registers, step counter.
  - Ports: clk, reset, load, op, a, b, step, last, result.
- Top level holds: the combinational single-cycle ops, the FSM, and the output registers.

## Test plan
- Reset: assert reset mid-mul (cycle 10 of 32) → Busy 0, Done 0, ALUResult 0, Zero 1 next cycle; no later Done.
- Single-cycle ops, WIDTH=32, one per cycle with no gaps:
  - add 0xFFFFFFFF+1 → 0, Zero 1
  - sub 5−7 → 0xFFFFFFFE
  - slt −1,1 → 1
  - sltu −1,1 → 0
  - sra 0x80000000>>4 → 0xF8000000
  - sll 1<<31 → 0x80000000
  - Each with Done high the cycle after Start.
- mul:
  - 0x0001_0000 × 0x0001_0000 → 0; Done exactly 33 cycles after Start, Busy high for 32 cycles.
  - 0xFFFFFFFF × 3 → 0xFFFFFFFD.
- divu/remu:
  - 100/7 → 14; remu 100,7 → 2.
  - divu x/0 → 0xFFFFFFFF; remu 0x1234/0 → 0x1234.
- Handshake:
  - Start pulsed during RUN with a different op → ignored, result matches the original op.
  - Start in the Done cycle → accepted, second result correct.
- Parameter: WIDTH=8 → mul 15×17 → 0xFF, divu 200/3 → 66; Done 9 cycles after Start.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and op-class helper for the iterative ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per step.
// result presents the value the current step produces, so the caller can commit it on the last step.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic             last,
  output logic [WIDTH-1:0] result
);

  localparam int SHW = $clog2(WIDTH);

  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc;     // product accumulator / partial remainder
  logic [WIDTH-1:0] shreg;   // multiplier (LSB-first) / dividend-in, quotient-out
  logic [WIDTH-1:0] opnd;    // multiplicand (shifts left) / divisor (static)
  logic [SHW-1:0]   count;

  logic             is_mul;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             no_borrow;
  logic [WIDTH-1:0] acc_n, shreg_n, opnd_n;

  always_comb begin
    is_mul    = (op_q == OP_MUL);
    mul_acc   = acc + (shreg[0] ? opnd : '0);
    rem_sh    = {acc, shreg[WIDTH-1]};
    // One extra bit so a zero divisor never reads as a borrow.
    diff      = {1'b0, rem_sh} - {2'b00, opnd};
    no_borrow = ~diff[WIDTH+1];
    acc_n     = is_mul ? mul_acc : (no_borrow ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]);
    shreg_n   = is_mul ? (shreg >> 1) : {shreg[WIDTH-2:0], no_borrow};
    opnd_n    = is_mul ? (opnd << 1) : opnd;
    result    = (op_q == OP_DIVU) ? shreg_n : acc_n;
    last      = (count == SHW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= '0;
    else if (step)
      count <= count + SHW'(1);
  end

  always_ff @(posedge clk) begin
    if (load) begin
      op_q  <= op;
      acc   <= '0;
      shreg <= (op == OP_MUL) ? b : a;
      opnd  <= (op == OP_MUL) ? a : b;
    end else if (step) begin
      acc   <= acc_n;
      shreg <= shreg_n;
      opnd  <= opnd_n;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Registered ALU: single-cycle ops complete on the Start edge, MUL/DIVU/REMU run WIDTH steps.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             Busy,
  output logic             Done,
  output logic             Zero,
  output logic [WIDTH-1:0] ALUResult
);

  localparam int SHW = $clog2(WIDTH);

  state_t state, state_n;

  logic                    is_sub;
  logic [WIDTH-1:0]        b_opnd;
  logic [WIDTH:0]          sum;
  logic [SHW-1:0]          shamt;
  logic signed [WIDTH-1:0] src_a_s;
  logic                    slt_bit;
  logic [WIDTH-1:0]        sc_result;

  logic             md_load, md_step, md_last;
  logic [WIDTH-1:0] md_result;
  logic             res_we;
  logic [WIDTH-1:0] res_n;

  // Shared adder: subtract/compare use inverted B with carry-in 1.
  always_comb begin
    is_sub  = (ALUControl == OP_SUB) || (ALUControl == OP_SLT) || (ALUControl == OP_SLTU);
    b_opnd  = is_sub ? ~SrcB : SrcB;
    sum     = {1'b0, SrcA} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, is_sub};
    shamt   = SrcB[SHW-1:0];
    src_a_s = SrcA;
    slt_bit = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) ? SrcA[WIDTH-1] : sum[WIDTH-1];
    case (ALUControl)
      OP_ADD, OP_SUB: sc_result = sum[WIDTH-1:0];
      OP_AND:         sc_result = SrcA & SrcB;
      OP_OR:          sc_result = SrcA | SrcB;
      OP_XOR:         sc_result = SrcA ^ SrcB;
      OP_SLT:         sc_result = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLTU:        sc_result = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
      OP_SLL:         sc_result = SrcA << shamt;
      OP_SRL:         sc_result = SrcA >> shamt;
      OP_SRA:         sc_result = src_a_s >>> shamt;
      default:        sc_result = '0;
    endcase
  end

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .load   (md_load),
    .op     (ALUControl),
    .a      (SrcA),
    .b      (SrcB),
    .step   (md_step),
    .last   (md_last),
    .result (md_result)
  );

  always_comb begin
    state_n = state;
    md_load = 1'b0;
    md_step = 1'b0;
    res_we  = 1'b0;
    res_n   = sc_result;
    case (state)
      IDLE: begin
        if (Start) begin
          if (is_iter(ALUControl)) begin
            md_load = 1'b1;
            state_n = RUN;
          end else begin
            res_we  = 1'b1;
          end
        end
      end
      RUN: begin
        md_step = 1'b1;
        if (md_last) begin
          res_we  = 1'b1;
          res_n   = md_result;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      Done      <= 1'b0;
      ALUResult <= '0;
    end else begin
      state <= state_n;
      Done  <= res_we;
      if (res_we)
        ALUResult <= res_n;
    end
  end

  assign Busy = (state == RUN);
  assign Zero = (ALUResult == '0);

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: 32-bit instance for op/handshake/reset cases, 8-bit instance for the parameter case.
module tb_alu_iter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;

  logic        d_start, d_busy, d_done, d_zero;
  logic [3:0]  d_ctl;
  logic [31:0] d_a, d_b, d_res;

  logic        e_start, e_busy, e_done, e_zero;
  logic [3:0]  e_ctl;
  logic [7:0]  e_a, e_b, e_res;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(32)) dut32 (
    .clk (clk), .reset (reset), .Start (d_start), .SrcA (d_a), .SrcB (d_b),
    .ALUControl (d_ctl), .Busy (d_busy), .Done (d_done), .Zero (d_zero), .ALUResult (d_res)
  );

  alu_iter #(.WIDTH(8)) dut8 (
    .clk (clk), .reset (reset), .Start (e_start), .SrcA (e_a), .SrcB (e_b),
    .ALUControl (e_ctl), .Busy (e_busy), .Done (e_done), .Zero (e_zero), .ALUResult (e_res)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic s, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      e_start = s; e_ctl = op; e_a = a[7:0]; e_b = b[7:0];
    end else begin
      d_start = s; d_ctl = op; d_a = a; d_b = b;
    end
  endtask

  // Issue a single-cycle op; the next cycle must show Done and the result.
  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    drive(0, 1'b1, op, a, b);
    tick;
    check({tag, "_res"}, d_res, exp);
    check({tag, "_done"}, {31'b0, d_done}, 32'd1);
  endtask

  // Issue an iterative op and follow it to Done, measuring latency and Busy length.
  task automatic run_iter(input bit w8, input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit glitch);
    int lat, busy_n, overlap, w;
    logic bz, dn;
    w = w8 ? 8 : 32;
    lat = 0; busy_n = 0; overlap = 0; dn = 1'b0;
    drive(w8, 1'b1, op, a, b);
    while (!dn && lat < 80) begin
      tick;
      lat++;
      bz = w8 ? e_busy : d_busy;
      dn = w8 ? e_done : d_done;
      if (bz) busy_n++;
      if (bz && dn) overlap++;
      if (!dn) begin
        if (glitch && lat == 5)
          drive(w8, 1'b1, OP_ADD, 32'h1, 32'h2);
        else if (glitch)
          drive(w8, 1'b0, OP_AND, 32'h0, 32'h0);
        else
          drive(w8, 1'b0, op, a, b);
      end
    end
    check({tag, "_latency"}, lat, w + 1);
    check({tag, "_busy_cycles"}, busy_n, w);
    check({tag, "_busy_done_overlap"}, overlap, 0);
    check({tag, "_res"}, w8 ? {24'b0, e_res} : d_res, exp);
  endtask

  initial begin
    int dones;
    reset = 1'b1;
    drive(0, 1'b0, OP_ADD, 32'h0, 32'h0);
    drive(1, 1'b0, OP_ADD, 32'h0, 32'h0);
    tick;
    tick;
    reset = 1'b0;
    check("rst_busy", {31'b0, d_busy}, 32'd0);
    check("rst_done", {31'b0, d_done}, 32'd0);
    check("rst_res",  d_res, 32'h0);
    check("rst_zero", {31'b0, d_zero}, 32'd1);

    // Back-to-back single-cycle ops, no idle gap.
    single("add",  OP_ADD,  32'hFFFF_FFFF, 32'h1, 32'h0);
    check("add_zero", {31'b0, d_zero}, 32'd1);
    single("sub",  OP_SUB,  32'd5, 32'd7, 32'hFFFF_FFFE);
    check("sub_zero", {31'b0, d_zero}, 32'd0);
    single("slt",  OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1);
    single("slt_pos_neg", OP_SLT, 32'd5, 32'hFFFF_FFFD, 32'd0);
    single("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    single("sra",  OP_SRA,  32'h8000_0000, 32'd4, 32'hF800_0000);
    single("sll",  OP_SLL,  32'h1, 32'd31, 32'h8000_0000);
    single("srl",  OP_SRL,  32'h8000_0000, 32'd4, 32'h0800_0000);
    single("xor",  OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    single("or",   OP_OR,   32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
    single("undef", 4'b1111, 32'h1234, 32'h5678, 32'h0);
    single("and",  OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    drive(0, 1'b0, OP_ADD, 32'h0, 32'h0);
    tick;
    check("idle_done", {31'b0, d_done}, 32'd0);
    check("idle_hold", d_res, 32'hF000_F000);

    // Start during RUN is ignored; then Start in each Done cycle chains ops.
    run_iter(0, "mul_ff_x3", OP_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b1);
    run_iter(0, "mul_2p16sq", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0);
    check("mul_zero_flag", {31'b0, d_zero}, 32'd1);
    run_iter(0, "divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    run_iter(0, "remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0);
    run_iter(0, "divu_by0", OP_DIVU, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1'b0);
    run_iter(0, "remu_by0", OP_REMU, 32'h1234, 32'h0, 32'h1234, 1'b0);
    drive(0, 1'b0, OP_ADD, 32'h0, 32'h0);
    tick;
    check("done_one_cycle", {31'b0, d_done}, 32'd0);

    // Narrow instance.
    run_iter(1, "w8_mul", OP_MUL, 32'd15, 32'd17, 32'hFF, 1'b0);
    run_iter(1, "w8_divu", OP_DIVU, 32'd200, 32'd3, 32'd66, 1'b0);
    drive(1, 1'b0, OP_ADD, 32'h0, 32'h0);

    // Reset mid-multiply aborts the op.
    drive(0, 1'b1, OP_MUL, 32'h7, 32'h9);
    tick;
    drive(0, 1'b0, OP_ADD, 32'h0, 32'h0);
    repeat (9) tick;
    check("pre_rst_busy", {31'b0, d_busy}, 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("midrst_busy", {31'b0, d_busy}, 32'd0);
    check("midrst_done", {31'b0, d_done}, 32'd0);
    check("midrst_res",  d_res, 32'h0);
    check("midrst_zero", {31'b0, d_zero}, 32'd1);
    dones = 0;
    repeat (40) begin
      tick;
      if (d_done) dones++;
    end
    check("midrst_no_done", dones, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
